// File: rtl/psum_pkg.sv
// Shared constants and FSM encodings for the partial-sum drain engine.
// The optional PSUM_DRAIN_RELU_EN build does not alter anything in this package.
package psum_pkg;

  localparam int unsigned DefOutDataWidth = 32;
  localparam int unsigned DefInDataWidth  = 8;
  localparam int unsigned DefAddrWidth    = 7;

  localparam int QMAX = 2 ** (DefInDataWidth - 1) - 1;
  localparam int QMIN = -(2 ** (DefInDataWidth - 1));

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRead  = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

endpackage

// File: rtl/psum_quant.sv
// Single-lane requantizer: arithmetic right shift, round-half-to-even, saturate.
// With PSUM_DRAIN_RELU_EN defined, the result is clamped to [0, max] instead.
module psum_quant
  import psum_pkg::*;
#(
  parameter int unsigned OUT_DATA_WIDTH = DefOutDataWidth,
  parameter int unsigned IN_DATA_WIDTH  = DefInDataWidth
) (
  input  logic [OUT_DATA_WIDTH-1:0] psum,
  input  logic [4:0]                shift,
  output logic [IN_DATA_WIDTH-1:0]  q
);

  localparam int unsigned Ow = OUT_DATA_WIDTH;
  localparam int QHi = 2 ** (IN_DATA_WIDTH - 1) - 1;
  localparam logic signed [Ow:0] Hi = (Ow + 1)'(QHi);
`ifndef PSUM_DRAIN_RELU_EN
  localparam int QLo = -(2 ** (IN_DATA_WIDTH - 1));
  localparam logic signed [Ow:0] Lo = (Ow + 1)'(QLo);
`endif

  logic signed [Ow:0] xe;
  logic signed [Ow:0] sh;
  logic signed [Ow:0] rnd;
  logic               guard;
  logic               rbit;
  logic               sticky;
  logic               inc;

  always_comb begin
    // One extra bit of headroom so the rounding increment never overflows.
    xe     = signed'({psum[Ow-1], psum});
    sh     = xe >>> shift;
    guard  = 1'b0;
    rbit   = 1'b0;
    sticky = 1'b0;
    if (shift >= 5'd1) guard  = |(psum & (Ow'(1) << (shift - 5'd1)));
    if (shift >= 5'd2) rbit   = |(psum & (Ow'(1) << (shift - 5'd2)));
    if (shift >= 5'd3) sticky = |(psum & ((Ow'(1) << (shift - 5'd2)) - Ow'(1)));
    inc = guard & (rbit | sticky | sh[0]);
    rnd = sh + (Ow + 1)'(inc);
  end

  always_comb begin
`ifdef PSUM_DRAIN_RELU_EN
    if (rnd[Ow])       q = '0;
    else if (rnd > Hi) q = Hi[IN_DATA_WIDTH-1:0];
    else               q = rnd[IN_DATA_WIDTH-1:0];
`else
    if (rnd > Hi)      q = Hi[IN_DATA_WIDTH-1:0];
    else if (rnd < Lo) q = Lo[IN_DATA_WIDTH-1:0];
    else               q = rnd[IN_DATA_WIDTH-1:0];
`endif
  end

endmodule

// File: rtl/psum_drain.sv
// Drains a finished psum buffer: issues reads, requantizes each row, streams it out.
// Build option PSUM_DRAIN_RELU_EN fuses a ReLU clamp into every lane.
module psum_drain
  import psum_pkg::*;
#(
  parameter int unsigned COL            = 8,
  parameter int unsigned OUT_DATA_WIDTH = DefOutDataWidth,
  parameter int unsigned IN_DATA_WIDTH  = DefInDataWidth,
  parameter int unsigned ADDR_WIDTH     = DefAddrWidth,
  parameter int unsigned RD_LATENCY     = 1,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ADDR_WIDTH:0]           num_rows,
  input  logic [4:0]                    shift,
  output logic                          busy,
  output logic                          done,
  output logic                          rd_en,
  output logic [ADDR_WIDTH-1:0]         rd_addr,
  input  logic [COL*OUT_DATA_WIDTH-1:0] rd_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [COL*IN_DATA_WIDTH-1:0]  out_data,
  output logic                          out_last
);

  localparam int unsigned RowW = COL * IN_DATA_WIDTH;
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IfW  = $clog2(RD_LATENCY + 1);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH:0]   rows_q;
  logic [4:0]            shift_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  done_q, done_d;
  logic [RD_LATENCY-1:0] vld_q, vld_d, lst_q, lst_d;
  logic [RowW-1:0]       mem_q [FIFO_DEPTH];
  logic                  mem_last_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IfW-1:0]        in_flight;
  logic [RowW-1:0]       q_row;
  logic                  accept, zero_start, issue, last_issue, push, pop, drain_empty;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LATENCY; i++) in_flight += IfW'(vld_q[i]);
  end

  assign accept     = (state_q == StIdle) && start && (num_rows != '0);
  assign zero_start = (state_q == StIdle) && start && (num_rows == '0);
  // Reserve a FIFO slot for every read in flight so backpressure can never overflow it.
  assign issue      = (state_q == StRead) && ((32'(in_flight) + 32'(cnt_q)) < FIFO_DEPTH);
  assign last_issue = issue && ({1'b0, addr_q} == rows_q - (ADDR_WIDTH + 1)'(1));
  assign vld_d      = RD_LATENCY'({vld_q, issue});
  assign lst_d      = RD_LATENCY'({lst_q, last_issue});
  assign push       = vld_q[RD_LATENCY-1];
  assign pop        = (cnt_q != '0) && out_ready;
  assign cnt_d      = cnt_q + CntW'(push) - CntW'(pop);
  assign drain_empty = (vld_d == '0) && (cnt_d == '0);
  assign done_d     = zero_start || ((state_q == StDrain) && drain_empty);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRead;
      StRead:  if (last_issue) state_d = StDrain;
      StDrain: if (drain_empty) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  for (genvar g = 0; g < COL; g++) begin : g_lane
    psum_quant #(
      .OUT_DATA_WIDTH(OUT_DATA_WIDTH),
      .IN_DATA_WIDTH (IN_DATA_WIDTH)
    ) u_quant (
      .psum (rd_data[g*OUT_DATA_WIDTH +: OUT_DATA_WIDTH]),
      .shift(shift_q),
      .q    (q_row[g*IN_DATA_WIDTH +: IN_DATA_WIDTH])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      rows_q   <= '0;
      shift_q  <= '0;
      addr_q   <= '0;
      done_q   <= 1'b0;
      vld_q    <= '0;
      lst_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i]      <= '0;
        mem_last_q[i] <= 1'b0;
      end
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      vld_q   <= vld_d;
      lst_q   <= lst_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        rows_q  <= num_rows;
        shift_q <= shift;
        addr_q  <= '0;
      end else if (issue && !last_issue) begin
        addr_q <= addr_q + ADDR_WIDTH'(1);
      end
      if (push) begin
        mem_q[wr_ptr_q]      <= q_row;
        mem_last_q[wr_ptr_q] <= lst_q[RD_LATENCY-1];
        wr_ptr_q             <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign rd_en     = issue;
  assign rd_addr   = addr_q;
  assign out_valid = (cnt_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign out_last  = mem_last_q[rd_ptr_q];

endmodule

// File: tb/tb_psum_drain.sv
// Directed bench for psum_drain: single-row quantization vectors plus multi-row sequences.
module tb_psum_drain;

  localparam int COL = 8;
  localparam int OW  = 32;
  localparam int IW  = 8;
  localparam int AW  = 7;
  localparam int FIFO_DEPTH = 4;
  localparam int NV  = 5;

  typedef int lanes_t [COL];
  typedef struct {
    logic [4:0]        shift;
    logic [COL*OW-1:0] din;
    logic [COL*IW-1:0] dout;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst, start, out_ready;
  logic [AW:0]       num_rows;
  logic [4:0]        shift;
  logic              busy, done, rd_en, out_valid, out_last;
  logic [AW-1:0]     rd_addr;
  logic [COL*OW-1:0] rd_data = '0;
  logic [COL*IW-1:0] out_data;
  logic [COL*OW-1:0] mem [2**AW];

  int n_tests = 0;
  int n_fail  = 0;
  int rd_cnt = 0, done_cnt = 0, last_addr = 0, outstanding = 0, max_out = 0;
  vec_t vecs [NV];

  psum_drain #(
    .COL(COL), .OUT_DATA_WIDTH(OW), .IN_DATA_WIDTH(IW), .ADDR_WIDTH(AW),
    .RD_LATENCY(1), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_rows(num_rows), .shift(shift),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Psum store model with one cycle of read latency, plus simple monitors.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data   <= mem[rd_addr];
      rd_cnt    <= rd_cnt + 1;
      last_addr <= int'(rd_addr);
    end
    if (done) done_cnt <= done_cnt + 1;
    if (rst) outstanding <= 0;
    else outstanding <= outstanding + (rd_en ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
    if (outstanding > max_out) max_out <= outstanding;
  end

  function automatic logic [COL*OW-1:0] p32(input lanes_t l);
    logic [COL*OW-1:0] r;
    for (int i = 0; i < COL; i++) r[i*OW +: OW] = l[i];
    return r;
  endfunction

  function automatic logic [COL*IW-1:0] p8(input lanes_t l);
    logic [COL*IW-1:0] r;
    for (int i = 0; i < COL; i++) r[i*IW +: IW] = IW'(l[i]);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_start(input int n, input int s);
    num_rows = (AW + 1)'(n);
    shift    = 5'(s);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Returns at the negedge before a handshake edge; ok=0 if none within the budget.
  task automatic wait_beat(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (out_valid && out_ready) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    bit ok;
    int beats, data_err, last_err, stall_err, base_rd, base_done;
    bit prev_stall;
    logic [63:0] prev_data;

    vecs[0].shift = 5'd11;
    vecs[0].din   = p32('{3072, 5120, 5121, -3072, -5120, 2047, 2048, 0});
    vecs[1].shift = 5'd0;
    vecs[1].din   = p32('{127, 128, -128, -129, 300000, -300000, 1, -1});
    vecs[2].shift = 5'd1;
    vecs[2].din   = p32('{1, 3, 5, -1, -3, 7, 254, 255});
    vecs[3].shift = 5'd31;
    vecs[3].din   = p32('{32'h7FFF_FFFF, 32'h8000_0000, 32'h4000_0000, 32'h4000_0001,
                          32'hC000_0000, 0, 32'h3FFF_FFFF, 32'hFFFF_FFFF});
    vecs[4].shift = 5'd4;
    vecs[4].din   = p32('{24, 40, 8, -8, -24, 1000, -10000, 17});
`ifdef PSUM_DRAIN_RELU_EN
    vecs[0].dout = p8('{2, 2, 3, 0, 0, 1, 1, 0});
    vecs[1].dout = p8('{127, 127, 0, 0, 127, 0, 1, 0});
    vecs[2].dout = p8('{0, 2, 2, 0, 0, 4, 127, 127});
    vecs[3].dout = p8('{1, 0, 0, 1, 0, 0, 0, 0});
    vecs[4].dout = p8('{2, 2, 0, 0, 0, 62, 0, 1});
`else
    vecs[0].dout = p8('{2, 2, 3, -2, -2, 1, 1, 0});
    vecs[1].dout = p8('{127, 127, -128, -128, 127, -128, 1, -1});
    vecs[2].dout = p8('{0, 2, 2, 0, -2, 4, 127, 127});
    vecs[3].dout = p8('{1, -1, 0, 1, 0, 0, 0, 0});
    vecs[4].dout = p8('{2, 2, 0, 0, -2, 62, -128, 1});
`endif

    rst = 1'b1; start = 1'b0; num_rows = '0; shift = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 0);
    check("reset_done", 64'(done), 0);
    check("reset_rd_en", 64'(rd_en), 0);
    check("reset_out_valid", 64'(out_valid), 0);
    check("reset_out_last", 64'(out_last), 0);
    check("reset_rd_addr", 64'(rd_addr), 0);
    check("reset_out_data", out_data, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single-row quantization vectors.
    out_ready = 1'b1;
    for (int k = 0; k < NV; k++) begin
      mem[0] = vecs[k].din;
      pulse_start(1, int'(vecs[k].shift));
      wait_beat(ok);
      check($sformatf("vec%0d_valid", k), 64'(ok), 1);
      check($sformatf("vec%0d_data", k), out_data, vecs[k].dout);
      check($sformatf("vec%0d_last", k), 64'(out_last), 1);
      @(negedge clk);
      check($sformatf("vec%0d_done", k), 64'(done), 1);
      check($sformatf("vec%0d_busy_low", k), 64'(busy), 0);
      @(negedge clk);
    end

    // Backpressure: 16 rows, random ready with a 20-cycle stall.
    for (int r = 0; r < 16; r++) mem[r] = {COL{32'(r)}};
    pulse_start(16, 0);
    beats = 0; stall_err = 0; prev_stall = 1'b0; prev_data = '0;
    for (int cyc = 0; cyc < 3000 && beats < 16; cyc++) begin
      out_ready = (cyc >= 4 && cyc < 24) ? 1'b0 : 1'($urandom_range(0, 1));
      if (prev_stall && (!out_valid || out_data !== prev_data)) stall_err++;
      if (out_valid && out_ready) begin
        check($sformatf("bp_beat%0d_data", beats), out_data, {COL{8'(beats)}});
        check($sformatf("bp_beat%0d_last", beats), 64'(out_last), 64'(beats == 15));
        beats++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      @(negedge clk);
    end
    check("bp_beat_count", 64'(beats), 16);
    check("bp_done", 64'(done), 1);
    check("bp_stable_while_stalled", 64'(stall_err), 0);
    out_ready = 1'b1;
    @(negedge clk);

    // Full buffer: 128 rows, lane 0 carries the row index.
    for (int r = 0; r < 128; r++) mem[r] = (COL * OW)'(r);
    base_rd = rd_cnt;
    pulse_start(128, 0);
    beats = 0; data_err = 0; last_err = 0;
    for (int cyc = 0; cyc < 2000 && beats < 128; cyc++) begin
      if (out_valid && out_ready) begin
        if (out_data !== 64'(beats)) data_err++;
        if (out_last !== (beats == 127)) last_err++;
        beats++;
      end
      @(negedge clk);
    end
    check("full_beats", 64'(beats), 128);
    check("full_data_order", 64'(data_err), 0);
    check("full_last_only_on_final", 64'(last_err), 0);
    check("full_last_rd_addr", 64'(last_addr), 127);
    check("full_rd_count", 64'(rd_cnt - base_rd), 128);
    check("full_done", 64'(done), 1);
    @(negedge clk);

    // Zero rows: no reads, done one cycle after start.
    base_rd = rd_cnt;
    pulse_start(0, 0);
    check("zero_done", 64'(done), 1);
    check("zero_busy", 64'(busy), 0);
    @(negedge clk);
    check("zero_done_single", 64'(done), 0);
    check("zero_no_reads", 64'(rd_cnt - base_rd), 0);

    // Start while busy must be ignored, including its shift.
    for (int r = 0; r < 6; r++) mem[r] = (COL * OW)'(r + 10);
    base_done = done_cnt;
    pulse_start(6, 0);
    @(negedge clk);
    check("sb_busy_before_restart", 64'(busy), 1);
    pulse_start(3, 5);
    beats = 0; data_err = 0;
    for (int cyc = 0; cyc < 500 && beats < 6; cyc++) begin
      if (out_valid && out_ready) begin
        if (out_data !== 64'(beats + 10)) data_err++;
        beats++;
      end
      @(negedge clk);
    end
    check("sb_beats", 64'(beats), 6);
    check("sb_data", 64'(data_err), 0);
    check("sb_done", 64'(done), 1);
    repeat (10) @(negedge clk);
    check("sb_single_done", 64'(done_cnt - base_done), 1);
    check("sb_idle_after", 64'(out_valid), 0);

    // Reset after 5 of 10 beats, then a fresh 2-row drain.
    for (int r = 0; r < 10; r++) mem[r] = (COL * OW)'(r + 20);
    pulse_start(10, 0);
    beats = 0;
    for (int cyc = 0; cyc < 500 && beats < 5; cyc++) begin
      if (out_valid && out_ready) beats++;
      @(negedge clk);
    end
    check("rst_mid_beats_before", 64'(beats), 5);
    base_done = done_cnt;
    rst = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", 64'(busy), 0);
    check("rst_mid_out_valid", 64'(out_valid), 0);
    check("rst_mid_rd_en", 64'(rd_en), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_no_done", 64'(done_cnt - base_done), 0);
    mem[0] = (COL * OW)'(100);
    mem[1] = (COL * OW)'(101);
    out_ready = 1'b1;
    pulse_start(2, 0);
    for (int b = 0; b < 2; b++) begin
      wait_beat(ok);
      check($sformatf("rst_fresh_beat%0d_valid", b), 64'(ok), 1);
      check($sformatf("rst_fresh_beat%0d_data", b), out_data, 64'(100 + b));
      check($sformatf("rst_fresh_beat%0d_last", b), 64'(out_last), 64'(b == 1));
      @(negedge clk);
    end
    check("rst_fresh_done", 64'(done), 1);

    check("occupancy_within_depth", 64'(max_out <= FIFO_DEPTH), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
